// File: rtl/nco_rate_decode_pkg.sv
// Shared constants and FSM encoding for the NCO rate decoder.
// The same ONE_KHZ constant is used by frequency_control_gen, so an encode/decode round trip agrees.
package nco_rate_decode_pkg;

    // round_down(2^46 * 1000 / 240 MHz): the control-word step for 1 kHz
    localparam logic [29:0] NCO_ONE_KHZ = 30'h1179EC9C;

    localparam int DIVIDEND_W = 46;
    localparam int REM_W      = 31;
    localparam int QUOT_W     = 46;
    localparam int CNT_W      = 6;

    localparam logic [CNT_W-1:0] LAST_ITER = 6'd45;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Round half up: compare 2*remainder with the divisor at 32 bits so no bit is lost.
    function automatic logic round_up(input logic [REM_W-1:0] rem,
                                      input logic [REM_W-1:0] divisor);
        return {rem, 1'b0} >= {1'b0, divisor};
    endfunction

endpackage

// File: rtl/serial_div_46x31.sv
// Serial restoring divider: 46-bit dividend, 31-bit divisor, one quotient bit per step.
module serial_div_46x31
    import nco_rate_decode_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [REM_W-1:0]      i_divisor,
    output logic [REM_W-1:0]      o_remainder,
    output logic [QUOT_W-1:0]     o_quotient,
    output logic [CNT_W-1:0]      o_count
);

    logic [DIVIDEND_W-1:0] r_dividend;
    logic [REM_W-1:0]      r_rem;
    logic [QUOT_W-1:0]     r_quot;
    logic [CNT_W-1:0]      r_count;

    logic [REM_W-1:0]      w_shift;
    logic                  w_fits;

    // The remainder stays below the divisor (< 2^30), so dropping its MSB on the shift is safe.
    assign w_shift = {r_rem[REM_W-2:0], r_dividend[DIVIDEND_W-1]};
    assign w_fits  = (w_shift >= i_divisor);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_count    <= '0;
        end else if (i_load) begin
            r_dividend <= i_dividend;
            r_rem      <= '0;
            r_quot     <= '0;
            r_count    <= '0;
        end else if (i_step) begin
            r_dividend <= {r_dividend[DIVIDEND_W-2:0], 1'b0};
            r_rem      <= w_fits ? (w_shift - i_divisor) : w_shift;
            r_quot     <= {r_quot[QUOT_W-2:0], w_fits};
            r_count    <= r_count + 1'b1;
        end
    end

    assign o_remainder = r_rem;
    assign o_quotient  = r_quot;
    assign o_count     = r_count;

endmodule

// File: rtl/nco_rate_decode.sv
// Decodes an NCO tuning word into a rate in kHz: serial divide by ONE_KHZ, round half up, saturate.
// valid/ready: start is accepted only in IDLE; done pulses one cycle when clock_rate/overflow are fresh.
module nco_rate_decode
    import nco_rate_decode_pkg::*;
#(
    parameter logic [29:0] ONE_KHZ = NCO_ONE_KHZ
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        start,
    input  logic [31:0] NCO,
    output logic [15:0] clock_rate,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [2:0]  state_1
);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_nco;
    logic [15:0]         r_rate;
    logic                r_ovf;

    logic                w_load;
    logic                w_step;
    logic                w_accept;
    logic                w_commit;
    logic [REM_W-1:0]    w_divisor;
    logic [REM_W-1:0]    w_rem;
    logic [QUOT_W-1:0]   w_quot;
    logic [CNT_W-1:0]    w_count;
    logic                w_round_up;
    logic [QUOT_W-1:0]   w_qp;
    logic                w_sat;

    assign w_divisor = {1'b0, ONE_KHZ};

    serial_div_46x31 u_div (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_dividend  ({r_nco, 14'd0}),
        .i_divisor   (w_divisor),
        .o_remainder (w_rem),
        .o_quotient  (w_quot),
        .o_count     (w_count)
    );

    assign w_round_up = round_up(w_rem, w_divisor);
    assign w_qp       = w_quot + {{(QUOT_W-1){1'b0}}, w_round_up};
    assign w_sat      = |w_qp[QUOT_W-1:16];

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_DIV;
            end
            ST_DIV: begin
                w_step = 1'b1;
                if (w_count == LAST_ITER) w_next = ST_ROUND;
            end
            ST_ROUND: begin
                w_commit = 1'b1;
                w_next   = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        // Abort wins over everything, including a start in the same cycle and a pending result.
        if (restart) begin
            w_next   = ST_IDLE;
            w_load   = 1'b0;
            w_step   = 1'b0;
            w_accept = 1'b0;
            w_commit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_nco   <= '0;
            r_rate  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_nco <= NCO;
            if (w_commit) begin
                r_rate <= w_sat ? 16'hFFFF : w_qp[15:0];
                r_ovf  <= w_sat;
            end
        end
    end

    assign clock_rate = r_rate;
    assign overflow   = r_ovf;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign state_1    = r_state;

endmodule

// File: tb/tb_nco_rate_decode.sv
// Directed bench for nco_rate_decode: known words, round trips, held start, restart and reset aborts.
module tb_nco_rate_decode;
  import nco_rate_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        start;
  logic [31:0] nco;
  logic [15:0] clock_rate;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [2:0]  state_1;

  int checks = 0;
  int errors = 0;
  logic [15:0] rate_before;

  nco_rate_decode dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .start      (start),
    .NCO        (nco),
    .clock_rate (clock_rate),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .state_1    (state_1)
  );

  // clock / reset
  always #2 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // model of frequency_control_gen: control word = rate * ONE_KHZ, NCO = cw[45:14]
  function automatic logic [31:0] fcg(input logic [15:0] rate);
    logic [63:0] cw;
    cw = 64'(rate) * 64'(NCO_ONE_KHZ);
    return cw[45:14];
  endfunction

  // driver: one start pulse, scramble NCO after the latch, count clock periods until done
  task automatic convert(input logic [31:0] word, input bit poke, output int lat);
    @(negedge clk);
    nco   = word;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nco   = $urandom;
    rate_before = clock_rate;
    lat = 1;
    while (!done && lat < 100) begin
      start = poke && (lat >= 5) && (lat <= 30);
      if (lat == 40) chk("rate_hold_div", 32'(clock_rate), 32'(rate_before));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic finish_pulse();
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic watch_no_done(input string tag);
    int n;
    n = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] rt [4];
    rt[0] = 16'd1; rt[1] = 16'd1000; rt[2] = 16'd40000; rt[3] = 16'd65535;

    rst = 1'b1; restart = 1'b0; start = 1'b0; nco = '0;
    #5;
    chk("rst_state", 32'(state_1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rate", 32'(clock_rate), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 0x01111111 * 2^14 / ONE_KHZ = 999.9999988 -> 1000
    convert(32'h01111111, 1'b0, lat);
    chk("k1000_lat", 32'(lat), 32'd49);
    chk("k1000_rate", 32'(clock_rate), 32'd1000);
    chk("k1000_ovf", 32'(overflow), 32'd0);
    finish_pulse();

    // 17895 * 2^14 = 293191680, just under one ONE_KHZ -> q=0, rounds up to 1
    convert(32'd17895, 1'b0, lat);
    chk("k1_rate", 32'(clock_rate), 32'd1);
    chk("k1_ovf", 32'(overflow), 32'd0);
    finish_pulse();

    convert(32'd0, 1'b0, lat);
    chk("zero_lat", 32'(lat), 32'd49);
    chk("zero_rate", 32'(clock_rate), 32'd0);
    chk("zero_ovf", 32'(overflow), 32'd0);
    finish_pulse();

    convert(32'hFFFFFFFF, 1'b0, lat);
    chk("max_rate", 32'(clock_rate), 32'hFFFF);
    chk("max_ovf", 32'(overflow), 32'd1);
    finish_pulse();

    for (int i = 0; i < 4; i++) begin
      convert(fcg(rt[i]), 1'b0, lat);
      chk("rt_rate", 32'(clock_rate), 32'(rt[i]));
      chk("rt_ovf", 32'(overflow), 32'd0);
      finish_pulse();
    end

    // start held high: back-to-back results 50 clocks apart
    @(negedge clk);
    nco = 32'h01111111;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_first_lat", 32'(lat), 32'd49);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 100);
    chk("held_spacing", 32'(lat), 32'd50);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_release_idle", 32'(busy), 32'd0);
    chk("held_rate", 32'(clock_rate), 32'd1000);

    // restart at DIV iteration 20 (period 22)
    @(negedge clk);
    nco = 32'd17895;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 22) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("abort_in_div", 32'(state_1), 32'd2);
    restart = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_state", 32'(state_1), 32'd0);
    chk("abort_rate_kept", 32'(clock_rate), 32'd1000);
    watch_no_done("abort_no_done");

    // start pulses while busy must be ignored
    convert(32'd17895, 1'b1, lat);
    chk("poke_lat", 32'(lat), 32'd49);
    chk("poke_rate", 32'(clock_rate), 32'd1);
    finish_pulse();

    // asynchronous reset mid-DIV
    @(negedge clk);
    nco = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_state", 32'(state_1), 32'd0);
    chk("arst_rate", 32'(clock_rate), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;
    watch_no_done("arst_no_done");

    convert(32'h01111111, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd49);
    chk("post_rst_rate", 32'(clock_rate), 32'd1000);
    chk("post_rst_ovf", 32'(overflow), 32'd0);
    finish_pulse();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_rate_decode.md
NCO_RATE_DECODE -- requirements
Module: nco_rate_decode

Interface
REQ-001 The module SHALL have these ports, one clock domain; reset is asynchronous and active-high:
- clk, input, 1: system clock (240 MHz domain).
- rst, input, 1: asynchronous active-high reset.
- restart, input, 1: synchronous abort; returns the block to IDLE.
- start, input, 1: request a conversion of NCO; sampled only in IDLE.
- NCO, input, 32: NCO tuning word, equal to control-word bits [45:14].
- clock_rate, output, 16: decoded rate in units of 1 kHz.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse; clock_rate and overflow valid from this cycle onward.
- overflow, output, 1: the decoded rate exceeded 65535 kHz and clock_rate was saturated.
- state_1, output, 3: current FSM state, for debug.

REQ-002 The module SHALL have one parameter: ONE_KHZ, default 30'h1179EC9C, meaning round down of (2^46 * 1000 / 240 MHz).

Function
REQ-003 The block SHALL compute clock_rate = round_half_up((NCO * 2^14) / ONE_KHZ), saturated to 16'hFFFF.
REQ-004 The division SHALL be serial restoring division, one quotient bit per clock.
- Dividend: {NCO, 14'd0}, 46 bits.
- Divisor: ONE_KHZ zero-extended to 31 bits.
- Partial remainder: 31 bits. Quotient: 46 bits.
REQ-005 The FSM states SHALL be IDLE=0, LOAD=1, DIV=2, ROUND=3, DONE=4; all other encodings SHALL go to IDLE.
REQ-006 In IDLE with start=1, the block SHALL go to LOAD and latch NCO; a change to the NCO input after this latch SHALL have no effect on the current conversion.
REQ-007 LOAD SHALL clear the remainder, the quotient and a 6-bit iteration counter, then go to DIV.
REQ-008 Each DIV cycle SHALL perform these steps, and leave DIV for ROUND after the 46th iteration (counter==45):
- shift the next dividend MSB into the remainder;
- if remainder >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0;
- increment the counter.
REQ-009 ROUND SHALL form q' = quotient + 1 when 2*remainder >= divisor, otherwise q' = quotient; the comparison SHALL be done with 32-bit width.
REQ-010 ROUND SHALL resolve the result and then go to DONE:
- q' > 65535: clock_rate = 16'hFFFF and overflow = 1;
- otherwise: clock_rate = q'[15:0] and overflow = 0.
REQ-011 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-012 done SHALL occur exactly 49 clocks after the edge that sampled start (1 LOAD + 46 DIV + 1 ROUND + 1 DONE).
REQ-013 busy SHALL be high in LOAD, DIV, ROUND and DONE, and low in IDLE.
REQ-014 start asserted while not in IDLE SHALL be ignored and not queued.
REQ-015 start held high continuously SHALL begin a new conversion on the first cycle back in IDLE; results are therefore spaced 50 clocks apart.
REQ-016 clock_rate and overflow SHALL hold their last values until the next ROUND; they SHALL not change during DIV.
REQ-017 restart=1 SHALL force IDLE on the next edge, clear busy and done, and leave clock_rate and overflow unchanged; restart takes priority over start in the same cycle.
REQ-018 NCO=0 SHALL yield clock_rate=0 and overflow=0 at the normal latency; there SHALL be no early exit.

Reset
REQ-019 While rst=1, asynchronously: state_1=IDLE and busy, done, overflow, clock_rate = 0; the remainder, quotient and counter SHALL be cleared.
REQ-020 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after reset release SHALL behave as from power-up.

Structure
REQ-021 A shared package SHALL hold the ONE_KHZ constant and the FSM state encodings; the existing frequency_control_gen SHALL use the same ONE_KHZ constant.
REQ-022 The divide datapath SHALL be one sub-module, serial_div_46x31, with load, step, remainder and quotient ports. The FSM and the rounding/saturation logic SHALL stay in the top level.
REQ-023 The design SHALL use no multipliers, dividers or RAM; target implementation size is 120-400 lines of RTL.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- NCO=32'h01111111, start pulse: done 49 clocks later, clock_rate=1000, overflow=0.
- NCO=32'd17895: clock_rate=1, overflow=0.
- NCO=32'd0: clock_rate=0, overflow=0, done still at +49.
- NCO=32'hFFFFFFFF: clock_rate=16'hFFFF, overflow=1.
- Round-trip: frequency_control_gen drives clock_rate in {1, 1000, 40000, 65535}; this block returns the identical value with overflow=0.
- Abort: restart pulse at DIV iteration 20, then rst pulse mid-DIV; no done pulse, busy=0 next cycle, start after release gives the correct result; start during busy is ignored.
